// File: rtl/vram_arb_pkg.sv
// ---------------------------------------------------------------------------
// vram_arb_pkg
// Shared types for the VRAM scan-out arbiter:
//   owner_e  - which client owns the next memory cycle
//   tag_t    - per-cycle pipeline tag that travels alongside a memory access
//   MEM_LAT  - cycles from the issue decision to read data at the arbiter
// ---------------------------------------------------------------------------
package vram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DISP   = 2'd1,
        CPU_WR = 2'd2,
        CPU_RD = 2'd3
    } owner_e;

    // Tags which consumer (if any) the read data of a cycle belongs to.
    typedef struct packed {
        logic disp;
        logic cpu_rd;
    } tag_t;

    // One cycle for the registered mem_* outputs plus one for the RAM read.
    localparam int MEM_LAT = 2;

    function automatic tag_t owner_to_tag(input owner_e owner);
        tag_t tag;
        tag.disp   = (owner == DISP);
        tag.cpu_rd = (owner == CPU_RD);
        return tag;
    endfunction

endpackage

// File: rtl/vram_scanout_arbiter_if.sv
// ---------------------------------------------------------------------------
// vram_scanout_arbiter_if
// CPU access port of the VRAM scan-out arbiter.
//   cpu_req/cpu_we/cpu_addr/cpu_wdata : request, held stable until accepted
//   cpu_ready                         : request accepted when cpu_req && cpu_ready
//   cpu_rvalid/cpu_rdata              : one-cycle read-data pulse
// master = CPU side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface vram_scanout_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_rvalid, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_rvalid, cpu_rdata
    );
endinterface

// File: rtl/vram_timing_delay.sv
// ---------------------------------------------------------------------------
// vram_timing_delay
// Delays {display_on, hsync, vsync} by MEM_LAT cycles so that they leave
// aligned with pixel data read from the VRAM.
//   pixel_clk, reset_n          : clock, synchronous active-low reset
//   display_on, hsync, vsync    : raw timing from the raster generator
//   de_o, hsync_o, vsync_o      : the same signals, MEM_LAT cycles later
// ---------------------------------------------------------------------------
module vram_timing_delay
    import vram_arb_pkg::*;
(
    input  logic pixel_clk,
    input  logic reset_n,
    input  logic display_on,
    input  logic hsync,
    input  logic vsync,
    output logic de_o,
    output logic hsync_o,
    output logic vsync_o
);

    // Each stage holds {display_on, hsync, vsync}; index 0 is the newest.
    logic [MEM_LAT-1:0][2:0] stage_d, stage_q;

    always_comb begin
        stage_d = {stage_q[MEM_LAT-2:0], {display_on, hsync, vsync}};
    end

    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign {de_o, hsync_o, vsync_o} = stage_q[MEM_LAT-1];

endmodule

// File: rtl/vram_scanout_arbiter.sv
// ---------------------------------------------------------------------------
// vram_scanout_arbiter
// Shares one single-port synchronous VRAM between display scan-out and a CPU
// port. Display fetches own every active-region cycle; the CPU is served in
// blanking. Timing is delayed to match memory latency so pix_* leave aligned.
//   pixel_clk, reset_n           : clock, synchronous active-low reset
//   hcounter, vcounter           : raster position from the timing generator
//   hsync, vsync, display_on     : raster timing from the timing generator
//   cpu                          : CPU access port (slave side)
//   mem_en/we/addr/wdata, rdata  : VRAM port, outputs registered
//   pix_data/de/hsync/vsync      : aligned video output
// ---------------------------------------------------------------------------
module vram_scanout_arbiter
    import vram_arb_pkg::*;
#(
    parameter int HACTIVE = 240,
    parameter int VACTIVE = 256,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8
) (
    input  logic                  pixel_clk,
    input  logic                  reset_n,
    input  logic [31:0]           hcounter,
    input  logic [31:0]           vcounter,
    input  logic                  hsync,
    input  logic                  vsync,
    input  logic                  display_on,
    vram_scanout_arbiter_if.slave cpu,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [DATA_W-1:0]     pix_data,
    output logic                  pix_de,
    output logic                  pix_hsync,
    output logic                  pix_vsync
);

    localparam logic [31:0] VACTIVE_W = 32'(VACTIVE);
    localparam logic [31:0] HACTIVE_W = 32'(HACTIVE);

    // The linear frame layout makes the line length implicit in disp_addr,
    // and display_on already encodes the horizontal position.
    logic unused_inputs;
    assign unused_inputs = ^{hcounter, HACTIVE_W};

    owner_e            owner_d, owner_q;
    logic              mem_en_d, mem_en_q;
    logic              mem_we_d, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_d, mem_wdata_q;
    logic [ADDR_W-1:0] disp_addr_d, disp_addr_q;
    tag_t              tag2_d, tag2_q;
    logic [DATA_W-1:0] rdata_hold_d, rdata_hold_q;

    // Issue decision: display always wins in the active region.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        owner_d     = IDLE;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if (display_on) begin
            owner_d    = DISP;
            mem_addr_d = disp_addr_q;
        end else if (cpu.cpu_req) begin
            owner_d    = cpu.cpu_we ? CPU_WR : CPU_RD;
            mem_addr_d = cpu.cpu_addr;
            if (cpu.cpu_we) begin
                mem_wdata_d = cpu.cpu_wdata;
            end
        end

        mem_en_d = (owner_d != IDLE);
        mem_we_d = (owner_d == CPU_WR);
    end

    // Scan address: cleared throughout vertical blanking, advanced per fetch.
    always_comb begin
        disp_addr_d = disp_addr_q;
        if (vcounter >= VACTIVE_W) begin
            disp_addr_d = '0;
        end else if (display_on) begin
            disp_addr_d = disp_addr_q + 1'b1;
        end
    end

    // owner_q is tag stage 1 (registered with mem_*); tag2_q lines up with
    // mem_rdata. Read data for the CPU is also kept so cpu_rdata holds.
    always_comb begin
        tag2_d       = owner_to_tag(owner_q);
        rdata_hold_d = tag2_q.cpu_rd ? mem_rdata : rdata_hold_q;
    end

    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            // NOTE: data registers are cleared too because every output must read 0 in reset.
            owner_q      <= IDLE;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            disp_addr_q  <= '0;
            tag2_q       <= '0;
            rdata_hold_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            owner_q      <= owner_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            disp_addr_q  <= disp_addr_d;
            tag2_q       <= tag2_d;
            rdata_hold_q <= rdata_hold_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Combinational so the CPU sees the stall in the cycle display_on rises.
    assign cpu.cpu_ready  = reset_n && !display_on;
    // Gated with reset_n so nothing leaks out before the reset edge clears tags.
    assign cpu.cpu_rvalid = reset_n && tag2_q.cpu_rd;
    assign cpu.cpu_rdata  = !reset_n     ? '0        :
                            tag2_q.cpu_rd ? mem_rdata : rdata_hold_q;
    assign pix_data       = (reset_n && tag2_q.disp) ? mem_rdata : '0;

    vram_timing_delay u_timing_delay (
        .pixel_clk  (pixel_clk),
        .reset_n    (reset_n),
        .display_on (display_on),
        .hsync      (hsync),
        .vsync      (vsync),
        .de_o       (pix_de),
        .hsync_o    (pix_hsync),
        .vsync_o    (pix_vsync)
    );

endmodule

// File: tb/tb_vram_scanout_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_scanout_arbiter
// Directed bench: tiny raster (4x2 active, 7 cycles per line, 4 lines per
// frame), a synchronous model RAM preloaded with value = address, and a
// reference copy of the expected VRAM contents for the visible addresses.
// ---------------------------------------------------------------------------
module tb_vram_scanout_arbiter;

    localparam int HACT   = 4;
    localparam int VACT   = 2;
    localparam int HTOT   = 7;
    localparam int VTOT   = 4;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    logic              pixel_clk = 1'b0;
    logic              reset_n;
    logic [31:0]       hcounter, vcounter;
    logic              hsync, vsync, display_on;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata, pix_data;
    logic              pix_de, pix_hsync, pix_vsync;

    always #5 pixel_clk = ~pixel_clk;

    vram_scanout_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu_if ();

    vram_scanout_arbiter #(
        .HACTIVE (HACT),
        .VACTIVE (VACT),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .pixel_clk  (pixel_clk),
        .reset_n    (reset_n),
        .hcounter   (hcounter),
        .vcounter   (vcounter),
        .hsync      (hsync),
        .vsync      (vsync),
        .display_on (display_on),
        .cpu        (cpu_if),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .pix_data   (pix_data),
        .pix_de     (pix_de),
        .pix_hsync  (pix_hsync),
        .pix_vsync  (pix_vsync)
    );

    // Model RAM: one-cycle read latency, writes counted.
    logic [7:0] ram [0:255];
    logic       preloaded = 1'b0;
    int         wr_count  = 0;

    always @(posedge pixel_clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 256; i++) ram[i] = 8'(i);
            preloaded = 1'b1;
        end
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr[7:0]] = mem_wdata;
                wr_count = wr_count + 1;
            end else begin
                mem_rdata <= ram[mem_addr[7:0]];
            end
        end
    end

    int         checks = 0;
    int         errors = 0;
    int         gh, gv;
    int         hist_h [3];
    int         hist_v [3];
    logic       hist_de [3];
    logic       hist_hs [3];
    logic       hist_vs [3];
    logic       pix_chk_en;
    logic [7:0] exp_vram [0:31];
    logic [4:0] exp_idx;
    int         wr_base;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_timing();
        hcounter   = 32'(gh);
        vcounter   = 32'(gv);
        display_on = (gh < HACT) && (gv < VACT);
        hsync      = (gh == 5);
        vsync      = (gv == 3);
    endtask

    // Ends the current cycle, presents the next raster position and, when
    // enabled, compares pix_* against the inputs of two cycles earlier.
    task automatic next_cycle();
        @(posedge pixel_clk);
        #1;
        for (int i = 2; i > 0; i--) begin
            hist_h[i]  = hist_h[i-1];
            hist_v[i]  = hist_v[i-1];
            hist_de[i] = hist_de[i-1];
            hist_hs[i] = hist_hs[i-1];
            hist_vs[i] = hist_vs[i-1];
        end
        gh++;
        if (gh == HTOT) begin
            gh = 0;
            gv = (gv + 1) % VTOT;
        end
        drive_timing();
        hist_h[0]  = gh;
        hist_v[0]  = gv;
        hist_de[0] = display_on;
        hist_hs[0] = hsync;
        hist_vs[0] = vsync;
        #1;
        if (pix_chk_en) begin
            exp_idx = 5'(hist_v[2] * HACT + hist_h[2]);
            check("pix_de",    32'(pix_de),    32'(hist_de[2]));
            check("pix_hsync", 32'(pix_hsync), 32'(hist_hs[2]));
            check("pix_vsync", 32'(pix_vsync), 32'(hist_vs[2]));
            check("pix_data",  32'(pix_data),  32'(hist_de[2] ? exp_vram[exp_idx] : 8'h00));
            check("wr_vs_disp", 32'(mem_en && mem_we && hist_de[1]), 32'(0));
        end
    endtask

    task automatic goto(input int h, input int v);
        int n = 0;
        while (!(gh == h && gv == v) && n < 200) begin
            next_cycle();
            n++;
        end
        check("goto_bound", 32'(gh == h && gv == v), 32'(1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_en"},    32'(mem_en),           32'(0));
        check({tag, "_mem_we"},    32'(mem_we),           32'(0));
        check({tag, "_mem_addr"},  32'(mem_addr),         32'(0));
        check({tag, "_mem_wdata"}, 32'(mem_wdata),        32'(0));
        check({tag, "_rvalid"},    32'(cpu_if.cpu_rvalid), 32'(0));
        check({tag, "_rdata"},     32'(cpu_if.cpu_rdata),  32'(0));
        check({tag, "_ready"},     32'(cpu_if.cpu_ready),  32'(0));
        check({tag, "_pix_data"},  32'(pix_data),         32'(0));
        check({tag, "_pix_de"},    32'(pix_de),           32'(0));
        check({tag, "_pix_hsync"}, 32'(pix_hsync),        32'(0));
        check({tag, "_pix_vsync"}, 32'(pix_vsync),        32'(0));
    endtask

    initial begin
        reset_n          = 1'b0;
        cpu_if.cpu_req   = 1'b0;
        cpu_if.cpu_we    = 1'b0;
        cpu_if.cpu_addr  = '0;
        cpu_if.cpu_wdata = '0;
        pix_chk_en       = 1'b0;
        for (int i = 0; i < 32; i++) exp_vram[i] = 8'(i);
        for (int i = 0; i < 3; i++) begin
            hist_h[i] = 0; hist_v[i] = 0;
            hist_de[i] = 1'b0; hist_hs[i] = 1'b0; hist_vs[i] = 1'b0;
        end
        gh = 0;
        gv = 2;
        drive_timing();

        // Reset state: everything 0, including cpu_ready in blanking.
        repeat (3) next_cycle();
        check_all_zero("reset");
        reset_n = 1'b1;
        #1;
        check("ready_after_reset", 32'(cpu_if.cpu_ready), 32'(1));
        next_cycle();
        next_cycle();
        pix_chk_en = 1'b1;

        // CPU write 0xA5 -> address 9 in vertical blanking.
        goto(5, 2);
        cpu_if.cpu_req   = 1'b1;
        cpu_if.cpu_we    = 1'b1;
        cpu_if.cpu_addr  = 16'd9;
        cpu_if.cpu_wdata = 8'hA5;
        #1;
        check("wr9_ready", 32'(cpu_if.cpu_ready), 32'(1));
        next_cycle();
        cpu_if.cpu_req = 1'b0;
        check("wr9_mem_en",    32'(mem_en),    32'(1));
        check("wr9_mem_we",    32'(mem_we),    32'(1));
        check("wr9_mem_addr",  32'(mem_addr),  32'(9));
        check("wr9_mem_wdata", 32'(mem_wdata), 32'h0000_00A5);
        exp_vram[9] = 8'hA5;

        // CPU read of 9 one cycle before display_on rises.
        goto(6, 3);
        cpu_if.cpu_req  = 1'b1;
        cpu_if.cpu_we   = 1'b0;
        cpu_if.cpu_addr = 16'd9;
        #1;
        check("rd9_ready", 32'(cpu_if.cpu_ready), 32'(1));
        next_cycle();
        cpu_if.cpu_req = 1'b0;
        check("rd9_mem_en",   32'(mem_en),            32'(1));
        check("rd9_mem_we",   32'(mem_we),            32'(0));
        check("rd9_mem_addr", 32'(mem_addr),          32'(9));
        check("rd9_rvalid_1", 32'(cpu_if.cpu_rvalid), 32'(0));
        next_cycle();
        check("rd9_rvalid_2", 32'(cpu_if.cpu_rvalid), 32'(1));
        check("rd9_rdata",    32'(cpu_if.cpu_rdata),  32'h0000_00A5);
        check("disp0_addr",   32'(mem_addr),          32'(0));
        check("disp0_we",     32'(mem_we),            32'(0));
        next_cycle();
        check("rd9_rvalid_3", 32'(cpu_if.cpu_rvalid), 32'(0));
        check("rd9_hold",     32'(cpu_if.cpu_rdata),  32'h0000_00A5);
        check("disp1_addr",   32'(mem_addr),          32'(1));

        // Write held through a whole active line: stalled, then one write.
        goto(0, 0);
        cpu_if.cpu_req   = 1'b1;
        cpu_if.cpu_we    = 1'b1;
        cpu_if.cpu_addr  = 16'd20;
        cpu_if.cpu_wdata = 8'h3C;
        wr_base          = wr_count;
        for (int i = 0; i < HACT; i++) begin
            #1;
            check("stall_ready", 32'(cpu_if.cpu_ready), 32'(0));
            next_cycle();
        end
        #1;
        check("stall_accept", 32'(cpu_if.cpu_ready), 32'(1));
        next_cycle();
        cpu_if.cpu_req = 1'b0;
        check("stall_mem_we",    32'(mem_we),    32'(1));
        check("stall_mem_addr",  32'(mem_addr),  32'(20));
        check("stall_mem_wdata", 32'(mem_wdata), 32'h0000_003C);
        exp_vram[20] = 8'h3C;
        next_cycle();
        check("stall_wr_count", 32'(wr_count - wr_base), 32'(1));
        goto(0, 1);
        check("stall_single_wr", 32'(wr_count - wr_base), 32'(1));

        // Reset the cycle after a CPU read accept: no rvalid, outputs 0.
        goto(0, 2);
        cpu_if.cpu_req  = 1'b1;
        cpu_if.cpu_we   = 1'b0;
        cpu_if.cpu_addr = 16'd9;
        #1;
        check("rst_rd_ready", 32'(cpu_if.cpu_ready), 32'(1));
        next_cycle();
        cpu_if.cpu_req = 1'b0;
        reset_n        = 1'b0;
        pix_chk_en     = 1'b0;
        #1;
        check("rst_ready_gated", 32'(cpu_if.cpu_ready), 32'(0));
        next_cycle();
        check_all_zero("midrst");
        reset_n = 1'b1;
        next_cycle();
        check("rst_no_rvalid", 32'(cpu_if.cpu_rvalid), 32'(0));
        next_cycle();
        check("rst_no_rvalid2", 32'(cpu_if.cpu_rvalid), 32'(0));
        pix_chk_en = 1'b1;

        // Back-to-back writes 0..3 in vertical blanking.
        goto(0, 3);
        wr_base        = wr_count;
        cpu_if.cpu_req = 1'b1;
        cpu_if.cpu_we  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cpu_if.cpu_addr  = 16'(i);
            cpu_if.cpu_wdata = 8'hC0 + 8'(i);
            #1;
            check("b2b_ready", 32'(cpu_if.cpu_ready), 32'(1));
            next_cycle();
        end
        cpu_if.cpu_req = 1'b0;
        check("b2b_last_we",    32'(mem_we),    32'(1));
        check("b2b_last_addr",  32'(mem_addr),  32'(3));
        check("b2b_last_wdata", 32'(mem_wdata), 32'h0000_00C3);
        for (int i = 0; i < 4; i++) exp_vram[i] = 8'hC0 + 8'(i);
        next_cycle();
        check("b2b_wr_count", 32'(wr_count - wr_base), 32'(4));

        // Next frame: scan restarts at 0 and line 0 shows the new words.
        goto(0, 0);
        next_cycle();
        check("restart_mem_en",   32'(mem_en),   32'(1));
        check("restart_mem_we",   32'(mem_we),   32'(0));
        check("restart_mem_addr", 32'(mem_addr), 32'(0));
        goto(0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_scanout_arbiter.md
Name: vram_scanout_arbiter

Overview:
- Shares one single-port synchronous video RAM between display scan-out and a CPU read/write port.
- Sits directly after the raster timing generator. It consumes that generator's hcounter, vcounter, hsync, vsync and display_on.
- Display fetches have absolute priority during the active region. The CPU is served during horizontal and vertical blanking.
- Video timing is delayed to match memory latency, so pixel data, data-enable and syncs leave aligned.

Parameters:
- HACTIVE, 240, active pixels per line; must match the timing generator.
- VACTIVE, 256, active lines per frame; must match the timing generator.
- ADDR_W, 16, VRAM word-address width.
- DATA_W, 8, VRAM/pixel data width.

Ports:
- pixel_clk  in  1  clock, shared with the timing generator
- reset_n  in  1  synchronous reset, active-low
- hcounter  in  32  horizontal position from the timing generator
- vcounter  in  32  vertical position from the timing generator
- hsync  in  1  from the timing generator
- vsync  in  1  from the timing generator
- display_on  in  1  from the timing generator
- cpu_req  in  1  CPU access request; held with stable fields until accepted
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ready  out  1  CPU transfer accepted when cpu_req && cpu_ready
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid
- cpu_rdata  out  DATA_W  CPU read data
- mem_en  out  1  VRAM enable (registered)
- mem_we  out  1  VRAM write enable (registered)
- mem_addr  out  ADDR_W  VRAM address (registered)
- mem_wdata  out  DATA_W  VRAM write data (registered)
- mem_rdata  in  DATA_W  VRAM read data, valid 1 cycle after mem_en && !mem_we
- pix_data  out  DATA_W  pixel, 0 when not active
- pix_de  out  1  display_on delayed 2 cycles
- pix_hsync  out  1  hsync delayed 2 cycles
- pix_vsync  out  1  vsync delayed 2 cycles

Behaviour:
- Clocking and reset:
  - One clock, pixel_clk. Reset is synchronous, active-low on reset_n.
  - While reset_n=0, every output is 0 and both pipeline tag stages are cleared.
  - A reset mid-transfer discards any pending cpu_rvalid. No pulse appears after reset deasserts.
- Issue FSM: state register is the owner of the next memory cycle, with states IDLE, DISP, CPU_WR, CPU_RD. It is evaluated every cycle:
  - display_on=1 -> DISP: mem_en=1, mem_we=0, mem_addr=disp_addr.
  - else cpu_req=1, cpu_we=1 -> CPU_WR: mem_en=1, mem_we=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
  - else cpu_req=1, cpu_we=0 -> CPU_RD: mem_en=1, mem_we=0, mem_addr=cpu_addr.
  - else -> IDLE: mem_en=0, mem_we=0. mem_addr and mem_wdata hold their values.
- cpu_ready:
  - cpu_ready = reset_n && !display_on. It is combinational, so the CPU sees the stall in the same cycle.
  - A CPU request during display_on is stalled, never dropped.
  - One transfer per accepted cycle; back-to-back CPU accesses run at full rate during blanking.
- Display address counter disp_addr (ADDR_W bits):
  - Cleared to 0 every cycle with vcounter >= VACTIVE.
  - Incremented by 1 after each cycle with display_on=1.
  - Wraps modulo 2^ADDR_W.
  - Frame layout is linear: address = line*HACTIVE + pixel.
- Tag pipeline: 2 stages, each carrying {disp, cpu_rd}.
  - Stage 1 mirrors the FSM decision registered with mem_*.
  - Stage 2 aligns with mem_rdata.
- Outputs at stage 2:
  - Stage-2 disp=1: pix_data = mem_rdata. Otherwise pix_data = 0.
  - Stage-2 cpu_rd=1: cpu_rvalid=1 and cpu_rdata = mem_rdata. Otherwise cpu_rvalid=0 and cpu_rdata holds its last value.
- Latency:
  - CPU read: 2 cycles from the accept cycle to cpu_rvalid.
  - Display: pix_* are timing inputs delayed exactly 2 cycles. pix_data is the word fetched in the same source cycle.
- Boundary conditions:
  - display_on rising while cpu_req is held: the CPU loses in that cycle and resumes at the first cycle with display_on=0.
  - Last active pixel of a line: the next blanking cycle is a CPU slot.
  - End of frame: disp_addr returns to 0 before line 0.
  - A write and a display read never share a cycle.
  - Read-after-write to the same address returns the new data, because the RAM port orders them.

Decomposition:
- Package vram_arb_pkg holds:
  - typedef owner_e {IDLE, DISP, CPU_WR, CPU_RD};
  - the pipeline-tag struct;
  - localparam MEM_LAT = 2.
- One natural sub-module: vram_timing_delay, a 2-stage shift of {display_on, hsync, vsync}.
- FSM, address counter and tag pipeline stay in the top module.

Test Plan:
- Small timing (HACTIVE=4, VACTIVE=2, blanking 3 cycles), model RAM preloaded with value = address, full frame -> pix_data on pix_de cycles reads 0,1,2,3 then 4,5,6,7; pix_data=0 otherwise; pix_* lag inputs by exactly 2 cycles.
- CPU write 0xA5 to address 9 during blanking -> cpu_ready=1 that cycle; next cycle mem_en=1, mem_we=1, mem_addr=9, mem_wdata=0xA5; no pix disturbance.
- CPU read of address 9 issued 1 cycle before display_on rises -> accepted; cpu_rvalid=1 with cpu_rdata=0xA5 2 cycles later; the display fetch of address 0 follows uninterrupted.
- cpu_req held through an entire active line -> cpu_ready=0 for all 4 active cycles, transfer accepted on the first blanking cycle, exactly one mem write.
- Reset asserted the cycle after a CPU read accept -> no cpu_rvalid, all outputs 0; after release, disp_addr restarts at 0 on the next frame.
- Back-to-back writes to addresses 0..3 during vertical blanking, then a displayed frame -> the first line shows the written data at pixels 0..3.
